// File: rtl/mem_access_unit_if.sv
// Data-memory bus between the memory-access stage and the data RAM.
// The master issues requests; the slave returns read data and the ack.
interface mem_access_unit_if #(
    parameter int DATA_W = 32
);
    logic              ram_en;
    logic [3:0]        ram_we;
    logic [DATA_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [DATA_W-1:0] ram_rdata;
    logic              ram_ack;

    modport master (
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM pipeline stage: issues loads/stores on the data bus, stalls the pipeline
// while waiting for ram_ack, aligns/extends load data and flags address/bus errors.
module mem_access_unit #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     result_in,
    input  logic [3:0]            mem_op_in,
    input  logic [DATA_W-1:0]     mem_wdata_in,
    input  logic                  write_reg_en_in,
    input  logic [REG_ADDR_W-1:0] write_reg_addr_in,
    input  logic                  write_hilo_en_in,
    input  logic [DATA_W-1:0]     write_hi_data_in,
    input  logic [DATA_W-1:0]     write_lo_data_in,
    output logic [DATA_W-1:0]     result_out,
    output logic                  write_reg_en_out,
    output logic [REG_ADDR_W-1:0] write_reg_addr_out,
    output logic                  write_hilo_en_out,
    output logic [DATA_W-1:0]     write_hi_data_out,
    output logic [DATA_W-1:0]     write_lo_data_out,
    mem_access_unit_if.master     bus,
    output logic                  stall_req,
    output logic                  addr_err,
    output logic                  bus_err
);
    localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {S_IDLE, S_WAIT} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [3:0]            req_op_q, req_op_d;
    logic [DATA_W-1:0]     req_addr_q, req_addr_d;
    logic [DATA_W-1:0]     req_wdata_q, req_wdata_d;
    logic [REG_ADDR_W-1:0] req_reg_q, req_reg_d;
    logic                  req_reg_en_q, req_reg_en_d;

    logic [3:0]            op;
    logic [DATA_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic                  is_load, is_store, misaligned;

    function automatic logic [DATA_W-1:0] load_ext(input logic [3:0] f_op,
                                                   input logic [1:0] lane,
                                                   input logic [DATA_W-1:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{lane, 3'b000} +: 8];
        h = rd[{lane[1], 4'b0000} +: 16];
        case (f_op)
            OP_LB:   load_ext = {{(DATA_W-8){b[7]}}, b};
            OP_LBU:  load_ext = {{(DATA_W-8){1'b0}}, b};
            OP_LH:   load_ext = {{(DATA_W-16){h[15]}}, h};
            OP_LHU:  load_ext = {{(DATA_W-16){1'b0}}, h};
            default: load_ext = rd;
        endcase
    endfunction

    function automatic logic [3:0] lane_mask(input logic [3:0] f_op, input logic [1:0] lane);
        case (f_op)
            OP_SB:   lane_mask = 4'b0001 << lane;
            OP_SH:   lane_mask = lane[1] ? 4'b1100 : 4'b0011;
            OP_SW:   lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] store_data(input logic [3:0] f_op,
                                                     input logic [DATA_W-1:0] wd);
        case (f_op)
            OP_SB:   store_data = {(DATA_W/8){wd[7:0]}};
            OP_SH:   store_data = {(DATA_W/16){wd[15:0]}};
            default: store_data = wd;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            req_op_q     <= '0;
            req_addr_q   <= '0;
            req_wdata_q  <= '0;
            req_reg_q    <= '0;
            req_reg_en_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            req_op_q     <= req_op_d;
            req_addr_q   <= req_addr_d;
            req_wdata_q  <= req_wdata_d;
            req_reg_q    <= req_reg_d;
            req_reg_en_q <= req_reg_en_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        req_op_d     = req_op_q;
        req_addr_d   = req_addr_q;
        req_wdata_d  = req_wdata_q;
        req_reg_d    = req_reg_q;
        req_reg_en_d = req_reg_en_q;

        // While waiting, the bus is driven purely from the captured request.
        op    = (state_q == S_WAIT) ? req_op_q    : mem_op_in;
        addr  = (state_q == S_WAIT) ? req_addr_q  : result_in;
        wdata = (state_q == S_WAIT) ? req_wdata_q : mem_wdata_in;

        is_load    = (op >= OP_LB) && (op <= OP_LW);
        is_store   = (op >= OP_SB) && (op <= OP_SW);
        misaligned = (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && addr[0]) ||
                     (((op == OP_LW) || (op == OP_SW)) && (addr[1:0] != 2'b00));

        result_out         = result_in;
        write_reg_en_out   = write_reg_en_in;
        write_reg_addr_out = (state_q == S_WAIT) ? req_reg_q : write_reg_addr_in;
        write_hilo_en_out  = write_hilo_en_in;
        write_hi_data_out  = write_hi_data_in;
        write_lo_data_out  = write_lo_data_in;
        bus.ram_en         = 1'b0;
        bus.ram_we         = 4'b0000;
        bus.ram_addr       = {addr[DATA_W-1:2], 2'b00};
        bus.ram_wdata      = store_data(op, wdata);
        stall_req          = 1'b0;
        addr_err           = 1'b0;
        bus_err            = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (is_load || is_store) begin
                    if (misaligned) begin
                        addr_err         = 1'b1;
                        write_reg_en_out = 1'b0;
                    end else begin
                        bus.ram_en   = 1'b1;
                        bus.ram_we   = lane_mask(op, addr[1:0]);
                        req_op_d     = mem_op_in;
                        req_addr_d   = result_in;
                        req_wdata_d  = mem_wdata_in;
                        req_reg_d    = write_reg_addr_in;
                        req_reg_en_d = write_reg_en_in;
                        if (bus.ram_ack) begin
                            result_out       = is_load ? load_ext(op, addr[1:0], bus.ram_rdata) : result_in;
                            write_reg_en_out = is_load && write_reg_en_in;
                        end else begin
                            stall_req         = 1'b1;
                            write_reg_en_out  = 1'b0;
                            write_hilo_en_out = 1'b0;
                            cnt_d             = '0;
                            state_d           = S_WAIT;
                        end
                    end
                end
            end
            S_WAIT: begin
                bus.ram_en = 1'b1;
                bus.ram_we = lane_mask(op, addr[1:0]);
                if (bus.ram_ack) begin
                    result_out       = is_load ? load_ext(op, addr[1:0], bus.ram_rdata) : req_addr_q;
                    write_reg_en_out = is_load && req_reg_en_q;
                    state_d          = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    bus.ram_en        = 1'b0;
                    bus.ram_we        = 4'b0000;
                    bus_err           = 1'b1;
                    write_reg_en_out  = 1'b0;
                    write_hilo_en_out = 1'b0;
                    state_d           = S_IDLE;
                end else begin
                    stall_req         = 1'b1;
                    write_reg_en_out  = 1'b0;
                    write_hilo_en_out = 1'b0;
                    cnt_d             = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Reset silences every control output without waiting for a clock edge.
        if (!rst) begin
            bus.ram_en        = 1'b0;
            bus.ram_we        = 4'b0000;
            stall_req         = 1'b0;
            addr_err          = 1'b0;
            bus_err           = 1'b0;
            write_reg_en_out  = 1'b0;
            write_hilo_en_out = 1'b0;
        end
    end
endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed corner cases plus randomized
// transactions compared against an arithmetic reference model.
module tb_mem_access_unit;
    localparam int DW = 32;
    localparam int RW = 5;
    localparam int TO = 255;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] result_in, mem_wdata_in, write_hi_data_in, write_lo_data_in;
    logic [3:0]    mem_op_in;
    logic          write_reg_en_in, write_hilo_en_in;
    logic [RW-1:0] write_reg_addr_in;
    logic [DW-1:0] result_out, write_hi_data_out, write_lo_data_out;
    logic          write_reg_en_out, write_hilo_en_out;
    logic [RW-1:0] write_reg_addr_out;
    logic          stall_req, addr_err, bus_err;

    int n_checks = 0;
    int n_pass   = 0;

    mem_access_unit_if #(.DATA_W(DW)) bus ();

    mem_access_unit #(.DATA_W(DW), .REG_ADDR_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .result_in(result_in), .mem_op_in(mem_op_in), .mem_wdata_in(mem_wdata_in),
        .write_reg_en_in(write_reg_en_in), .write_reg_addr_in(write_reg_addr_in),
        .write_hilo_en_in(write_hilo_en_in), .write_hi_data_in(write_hi_data_in),
        .write_lo_data_in(write_lo_data_in),
        .result_out(result_out), .write_reg_en_out(write_reg_en_out),
        .write_reg_addr_out(write_reg_addr_out), .write_hilo_en_out(write_hilo_en_out),
        .write_hi_data_out(write_hi_data_out), .write_lo_data_out(write_lo_data_out),
        .bus(bus), .stall_req(stall_req), .addr_err(addr_err), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Reference model: access size, load extension, lane enables, replicated data.
    function automatic int unsigned op_size(input int op);
        case (op)
            1, 2, 6: return 1;
            3, 4, 7: return 2;
            5, 8:    return 4;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] m_load(input int op, input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> (8 * (a % 4));
        if (op_size(op) == 1) begin
            v = v % 256;
            if (op == 1 && v >= 128) v = v - 32'd256;
        end else if (op_size(op) == 2) begin
            v = v % 65536;
            if (op == 3 && v >= 32768) v = v - 32'd65536;
        end
        return v;
    endfunction

    function automatic logic [31:0] m_we(input int op, input logic [31:0] a);
        if (op < 6) return 0;
        if (op_size(op) == 1) return 32'd1 << (a % 4);
        if (op_size(op) == 2) return 32'd3 << (a % 4);
        return 32'd15;
    endfunction

    function automatic logic [31:0] m_wdata(input int op, input logic [31:0] wd);
        if (op == 6) return (wd % 256) * 32'h0101_0101;
        if (op == 7) return (wd % 65536) * 32'h0001_0001;
        return wd;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic run_txn(input int op, input logic [31:0] a, input logic [31:0] wd,
                           input logic regen, input logic [4:0] regaddr,
                           input logic [31:0] rd, input int lat);
        int unsigned sz;
        logic        hl;
        hl = 1'($urandom);
        result_in = a; mem_op_in = 4'(op); mem_wdata_in = wd;
        write_reg_en_in = regen; write_reg_addr_in = regaddr;
        write_hilo_en_in = hl; write_hi_data_in = $urandom; write_lo_data_in = $urandom;
        bus.ram_rdata = rd;
        sz = op_size(op);
        if (sz == 0) begin
            bus.ram_ack = 1'($urandom);
            #4;
            chk("none_result", result_out, a);
            chk("none_regen", 32'(write_reg_en_out), 32'(regen));
            chk("none_regaddr", 32'(write_reg_addr_out), 32'(regaddr));
            chk("none_hilo_en", 32'(write_hilo_en_out), 32'(hl));
            chk("none_hi", write_hi_data_out, write_hi_data_in);
            chk("none_ctrl", {bus.ram_en, stall_req, addr_err, bus_err}, 0);
            next_cycle();
        end else if (a % sz != 0) begin
            bus.ram_ack = 1'($urandom);
            #4;
            chk("misalign_err", 32'(addr_err), 1);
            chk("misalign_ctrl", {bus.ram_en, write_reg_en_out, stall_req, bus_err}, 0);
            next_cycle();
        end else begin
            for (int c = 0; c <= lat; c++) begin
                if (c > 0 && c < lat) begin
                    result_in = $urandom; mem_wdata_in = $urandom;
                end else begin
                    result_in = a; mem_wdata_in = wd;
                end
                bus.ram_ack = (c == lat);
                #4;
                chk("ram_en", 32'(bus.ram_en), 1);
                chk("ram_addr", bus.ram_addr, a & ~32'd3);
                chk("ram_we", 32'(bus.ram_we), m_we(op, a));
                if (op >= 6) chk("ram_wdata", bus.ram_wdata, m_wdata(op, wd));
                if (c < lat) begin
                    chk("wait_stall", 32'(stall_req), 1);
                    chk("wait_wb", {write_reg_en_out, write_hilo_en_out}, 0);
                end else begin
                    chk("done_stall", 32'(stall_req), 0);
                    chk("done_result", result_out, (op <= 5) ? m_load(op, a, rd) : a);
                    chk("done_regen", 32'(write_reg_en_out), (op <= 5) ? 32'(regen) : 0);
                    if (op <= 5) chk("done_regaddr", 32'(write_reg_addr_out), 32'(regaddr));
                    chk("done_hilo_en", 32'(write_hilo_en_out), 32'(hl));
                    chk("done_errs", {addr_err, bus_err}, 0);
                end
                next_cycle();
            end
        end
        bus.ram_ack = 1'b0;
    endtask

    initial begin
        int          op;
        logic [31:0] a;
        rst = 1'b0;
        result_in = 32'h100; mem_op_in = 4'd5; mem_wdata_in = 0;
        write_reg_en_in = 1'b1; write_reg_addr_in = 5'd3; write_hilo_en_in = 1'b1;
        write_hi_data_in = 0; write_lo_data_in = 0;
        bus.ram_ack = 1'b0; bus.ram_rdata = 0;
        #4;
        chk("reset_outputs", {bus.ram_en, bus.ram_we, stall_req, addr_err, bus_err,
                              write_reg_en_out, write_hilo_en_out}, 0);
        next_cycle();
        next_cycle();
        rst = 1'b1;
        mem_op_in = 4'd0;
        next_cycle();

        // Directed corner cases.
        run_txn(5, 32'h100, 32'h0, 1'b1, 5'd7, 32'hDEAD_BEEF, 0);
        run_txn(1, 32'h103, 32'h0, 1'b1, 5'd8, 32'h8011_2233, 3);
        run_txn(2, 32'h103, 32'h0, 1'b1, 5'd9, 32'h8011_2233, 3);
        run_txn(7, 32'h102, 32'h0000_ABCD, 1'b1, 5'd1, 32'h0, 1);
        run_txn(5, 32'h101, 32'h0, 1'b1, 5'd2, 32'h0, 0);
        run_txn(0, 32'h1234_5678, 32'h0, 1'b1, 5'd4, 32'h0, 0);
        run_txn(6, 32'h201, 32'h0000_00A5, 1'b1, 5'd5, 32'h0, 2);
        run_txn(3, 32'h402, 32'h0, 1'b1, 5'd6, 32'h9ABC_1234, 0);

        // SW that never gets acked: bus error after TIMEOUT wait cycles.
        result_in = 32'h200; mem_op_in = 4'd8; mem_wdata_in = 32'h1111_2222;
        write_reg_en_in = 1'b0; bus.ram_ack = 1'b0;
        for (int c = 0; c <= TO; c++) begin
            #4;
            chk("to_stall", {stall_req, bus_err, bus.ram_en}, 3'b101);
            next_cycle();
        end
        #4;
        chk("to_buserr", {bus_err, stall_req, bus.ram_en, write_reg_en_out}, 4'b1000);
        next_cycle();
        mem_op_in = 4'd0;
        #4;
        chk("to_idle", {bus_err, stall_req}, 0);
        next_cycle();

        // Reset in the second cycle of a stalled LW.
        result_in = 32'h300; mem_op_in = 4'd5; write_reg_en_in = 1'b1;
        #4;
        chk("rst_issue", 32'(stall_req), 1);
        next_cycle();
        #4;
        chk("rst_wait", 32'(stall_req), 1);
        rst = 1'b0;
        #1;
        chk("rst_async", {bus.ram_en, stall_req, write_reg_en_out, bus_err, addr_err}, 0);
        next_cycle();
        mem_op_in = 4'd0;
        next_cycle();
        rst = 1'b1;
        #2;
        chk("rst_release", {bus_err, stall_req}, 0);
        next_cycle();
        run_txn(5, 32'h304, 32'h0, 1'b1, 5'd10, 32'hCAFE_F00D, 2);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 12));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~32'd3 | (32'($urandom_range(0, 3)) & ((op_size(op) == 1) ? 3 : 2));
            run_txn(op, a, $urandom, 1'($urandom), 5'($urandom), $urandom, int'($urandom_range(0, 4)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 32: data and address width.
REQ-002 SHALL have parameter REG_ADDR_W, default 5: register-file address width.
REQ-003 SHALL have parameter TIMEOUT, default 255: maximum wait cycles for ram_ack before bus error.
REQ-004 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous, active-low.
REQ-006 SHALL have ports result_in  in  DATA_W and mem_op_in  in  4: EX/MEM result (ALU value or effective address); op code 0=NONE, 1=LB, 2=LBU, 3=LH, 4=LHU, 5=LW, 6=SB, 7=SH, 8=SW, others treated as NONE.
REQ-007 SHALL have ports mem_wdata_in  in  DATA_W, write_reg_en_in  in  1, write_reg_addr_in  in  REG_ADDR_W, write_hilo_en_in  in  1, write_hi_data_in/write_lo_data_in  in  DATA_W: store data and writeback controls from EX/MEM.
REQ-008 SHALL have matching outputs result_out, write_reg_en_out, write_reg_addr_out, write_hilo_en_out, write_hi_data_out, write_lo_data_out toward MEM/WB.
REQ-009 SHALL have ports ram_en  out  1, ram_we  out  4, ram_addr  out  DATA_W, ram_wdata  out  DATA_W, ram_rdata  in  DATA_W, ram_ack  in  1: data-memory bus.
REQ-010 SHALL have ports stall_req  out  1, addr_err  out  1, bus_err  out  1.

Function
REQ-011 SHALL implement FSM states IDLE and WAIT plus an 8-bit-or-wider wait counter.
REQ-012 Non-memory op (NONE) SHALL pass all writeback inputs to outputs unchanged, no bus activity, zero latency.
REQ-013 Alignment: LH/LHU/SH need addr[0]=0; LW/SW need addr[1:0]=0; misaligned SHALL give addr_err=1, ram_en=0, write_reg_en_out=0, stall_req=0, state stays IDLE.
REQ-014 In IDLE with aligned memory op, SHALL drive ram_en=1, ram_addr={addr[DATA_W-1:2],2'b00}, and capture op, address, store data, reg address into internal request registers.
REQ-015 Store byte lanes: SB ram_we=1<<addr[1:0], data replicated in all bytes; SH ram_we=addr[1]?4'b1100:4'b0011, halfword replicated; SW ram_we=4'b1111; loads ram_we=0.
REQ-016 If ram_ack=1 in issue cycle, SHALL complete same cycle (zero-wait), stay IDLE, stall_req=0.
REQ-017 If ram_ack=0 in issue cycle, SHALL assert stall_req=1, go to WAIT at next edge, counter cleared.
REQ-018 In WAIT, bus outputs SHALL come from the request registers, held stable every cycle regardless of input changes.
REQ-019 In WAIT, stall_req=1 and write_reg_en_out=0, write_hilo_en_out=0 while ram_ack=0; counter increments each cycle.
REQ-020 In WAIT with ram_ack=1, SHALL complete that cycle: stall_req=0, writeback outputs valid, return to IDLE next edge.
REQ-021 Load result: byte/halfword selected by addr[1:0] (little-endian), LB/LH sign-extended, LBU/LHU zero-extended, LW full word; result_out=extended data, write_reg_en_out=write_reg_en_in on completion.
REQ-022 Store completion SHALL output write_reg_en_out=0 and result_out=result_in.
REQ-023 Counter reaching TIMEOUT with ram_ack=0 SHALL pulse bus_err=1 for one cycle, drop ram_en, stall_req=0, write_reg_en_out=0, return to IDLE.
REQ-024 ram_ack received in IDLE with no request outstanding SHALL be ignored.

Reset
REQ-025 rst=0 SHALL immediately force state IDLE, counter 0, request registers 0, independent of clk.
REQ-026 During reset, ram_en=0, ram_we=0, stall_req=0, addr_err=0, bus_err=0, write_reg_en_out=0, write_hilo_en_out=0.
REQ-027 Reset asserted in WAIT SHALL abandon the access with no writeback and no bus_err.

Verification
REQ-028 LW addr 0x100, ram_ack same cycle, rdata 0xDEADBEEF -> result_out=0xDEADBEEF, stall_req never 1.
REQ-029 LB addr 0x103, ack after 3 cycles, rdata 0x80112233 -> stall_req=1 for 3 cycles, result_out=0xFFFFFF80; LBU same -> 0x00000080.
REQ-030 SH addr 0x102, wdata 0x0000ABCD -> ram_we=4'b1100, ram_wdata=0xABCDABCD, ram_addr=0x100, write_reg_en_out=0.
REQ-031 LW addr 0x101 -> addr_err=1, ram_en=0, write_reg_en_out=0 in same cycle.
REQ-032 SW with ram_ack held 0 -> bus_err pulse after TIMEOUT wait cycles, stall_req released, FSM IDLE.
REQ-033 rst=0 mid-WAIT (cycle 2 of LW) -> ram_en=0, stall_req=0 asynchronously; after release next op issues normally.
